// File: rtl/aes_iter_encrypter.sv
// aes_iter_encrypter: iterative FIPS-197 AES encryption core, one round per
// clock, with the key schedule expanded on the fly from a KEY_BITS-wide key
// register. No expanded schedule is stored.
//
// Parameters:
//   KEY_BITS    128 (10 rounds) or 256 (14 rounds); anything else fails elaboration
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready        plaintext + key handshake (in_ready only in IDLE)
//   in_block[127:0]          plaintext, byte i = bits [8i+7:8i] = row i%4, col i/4
//   in_key[KEY_BITS-1:0]     cipher key, same byte order
//   out_valid/out_ready      ciphertext handshake, out_block held until taken
//   out_block[127:0]         ciphertext, same byte order
//   busy                     high whenever the FSM is not in IDLE
//   blocks_done[31:0]        completed-block counter
// Optional feature:
//   AES_BLOCK_CNT_EN         when defined, blocks_done counts out_valid && out_ready
//                            handshakes (wrapping); otherwise it is tied to 0.
module aes_iter_encrypter #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_block,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block,
  output logic                busy,
  output logic [31:0]         blocks_done
);

  localparam logic [3:0] NR    = (KEY_BITS == 256) ? 4'd14 : 4'd10;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_encrypter: KEY_BITS must be 128 or 256");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, 0 maps to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns: out[r][c] = in[r][(c+r)%4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Derives the next four schedule words from the four words Nk positions back
  // and the most recent word. Word bytes are packed low byte first, so RotWord
  // moves the low byte to the top.
  function automatic logic [127:0] expand4(input logic [127:0] prev, input logic [31:0] last,
                                           input logic rot, input logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t  = rot ? (sub_word({last[7:0], last[31:8]}) ^ {24'h000000, rcon}) : sub_word(last);
    n0 = prev[31:0]   ^ t;
    n1 = prev[63:32]  ^ n0;
    n2 = prev[95:64]  ^ n1;
    n3 = prev[127:96] ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  logic [1:0]          fsm_r;
  logic [3:0]          round_r;
  logic [7:0]          rcon_r;
  logic [127:0]        state_r;
  logic [KEY_BITS-1:0] key_r;
  logic [127:0]        rk_s;
  logic [KEY_BITS-1:0] next_key_s;
  logic                rot_s;
  logic [127:0]        sr_s;
  logic [127:0]        mc_s;

  // 128-bit keys: the register holds the previous round key and each round
  // derives the next. 256-bit keys: the upper half is the current round key and
  // the window slides by four words, alternating RotWord+Rcon and SubWord-only.
  if (KEY_BITS == 256) begin : g_ks256
    assign rot_s      = round_r[0];
    assign rk_s       = key_r[255:128];
    assign next_key_s = {expand4(key_r[127:0], key_r[255:224], rot_s, rcon_r), key_r[255:128]};
  end else begin : g_ks128
    assign rot_s      = 1'b1;
    assign rk_s       = expand4(key_r[127:0], key_r[127:96], 1'b1, rcon_r);
    assign next_key_s = rk_s;
  end

  assign sr_s = shift_rows(sub_bytes(state_r));
  assign mc_s = mix_columns(sr_s);

  // Control FSM, round datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_block <= 128'h0;
      round_r   <= 4'd0;
      rcon_r    <= 8'h00;
      state_r   <= 128'h0;
      key_r     <= '0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (in_valid) begin
            state_r  <= in_block ^ in_key[127:0];
            key_r    <= in_key;
            round_r  <= 4'd1;
            rcon_r   <= 8'h01;
            fsm_r    <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          if (round_r == NR) begin
            out_block <= sr_s ^ rk_s;
            out_valid <= 1'b1;
            fsm_r     <= DONE;
          end else begin
            state_r <= mc_s ^ rk_s;
            key_r   <= next_key_s;
            rcon_r  <= rot_s ? xtime(rcon_r) : rcon_r;
            round_r <= round_r + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            round_r   <= 4'd0;
            fsm_r     <= IDLE;
          end
        end
        default: begin
          fsm_r     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          round_r   <= 4'd0;
        end
      endcase
    end
  end

`ifdef AES_BLOCK_CNT_EN
  logic [31:0] cnt_r;

  // Completed-block counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 32'd0;
    end else if (out_valid && out_ready) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign blocks_done = cnt_r;
`else
  assign blocks_done = 32'd0;
`endif

endmodule
